// File: rtl/stopwatch_display.sv
// stopwatch_display
//   Converts the stopwatch time (milliseconds) into MM:SS.mmm digits with a
//   multi-cycle subtract-based converter, and drives the Nexys A7 8-digit
//   multiplexed seven-segment display. The display blinks while the
//   countdown-expired flag is high.
//
// Ports
//   clk       in   system clock (100 MHz)
//   rst       in   asynchronous active-high reset
//   t         in   [T_W-1:0] stopwatch time in ms, unsigned
//   zero      in   countdown expired; enables blinking
//   an        out  [7:0] digit anodes, active-low, an[7] leftmost (always blank)
//   seg       out  [6:0] segments {g,f,e,d,c,b,a}, active-low
//   dp        out  decimal point, active-low (lit after minutes and seconds)
//   ovf       out  displayed value is saturated at 99:59.999
//   cvt_done  out  one-cycle pulse, high the cycle after new digits commit
module stopwatch_display #(
  parameter int T_W         = 23,
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [T_W-1:0] t,
  input  logic           zero,
  output logic [7:0]     an,
  output logic [6:0]     seg,
  output logic           dp,
  output logic           ovf,
  output logic           cvt_done
);

  localparam int RW      = (T_W > 23) ? T_W : 23;
  localparam int SCAN_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [RW-1:0] MS_PER_MIN = RW'(60000);
  localparam logic [RW-1:0] MS_MAX_REM = RW'(59999);
  localparam logic [RW-1:0] MS_PER_SEC = RW'(1000);
  localparam logic [RW-1:0] MS_100     = RW'(100);
  localparam logic [RW-1:0] MS_10      = RW'(10);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MIN,
    S_SEC,
    S_BCD,
    S_COMMIT
  } state_t;

  state_t state_q, state_d;

  // Converter working registers. r holds the remaining milliseconds; after
  // SEC it is the ms field, and BCD reduces it further to the units digit.
  // mcnt/scnt likewise end up holding their own units digit.
  logic [RW-1:0] r_q, r_d;
  logic [6:0]    mcnt_q, mcnt_d;
  logic [5:0]    scnt_q, scnt_d;
  logic          sat_q, sat_d;
  logic [3:0]    min_t_q, min_t_d;
  logic [3:0]    sec_t_q, sec_t_d;
  logic [3:0]    ms_h_q, ms_h_d;
  logic [3:0]    ms_t_q, ms_t_d;
  logic          ms_ph_q, ms_ph_d;   // 0: extracting hundreds, 1: tens

  // Committed display digits, index matches the anode bit.
  logic [6:0][3:0] dig_q, dig_d;
  logic            ovf_q, ovf_d;
  logic            cvt_done_q, cvt_done_d;

  // Scan / blink timing.
  logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [2:0]         slot_q, slot_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               phase_on_q, phase_on_d;

  logic [7:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic       dp_q, dp_d;

  // FSM strobes.
  logic cap_en, min_en, sec_en, bcd_en, commit_en;
  logic min_step, bcd_done;
  logic scan_wrap, blink_wrap, blank;
  logic [3:0] cur_dig;

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    case (d)
      4'd0:    seg_enc = 7'h40;
      4'd1:    seg_enc = 7'h79;
      4'd2:    seg_enc = 7'h24;
      4'd3:    seg_enc = 7'h30;
      4'd4:    seg_enc = 7'h19;
      4'd5:    seg_enc = 7'h12;
      4'd6:    seg_enc = 7'h02;
      4'd7:    seg_enc = 7'h78;
      4'd8:    seg_enc = 7'h00;
      4'd9:    seg_enc = 7'h10;
      default: seg_enc = 7'h7F;
    endcase
  endfunction

  assign min_step = (r_q >= MS_PER_MIN) && (mcnt_q < 7'd99);
  assign bcd_done = (mcnt_q < 7'd10) && (scnt_q < 6'd10) && ms_ph_q && (r_q < MS_10);

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default first so every path assigns; otherwise a latch is inferred.
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_MIN;
      S_MIN:    if (!min_step) state_d = S_SEC;
      S_SEC:    if (r_q < MS_PER_SEC) state_d = S_BCD;
      S_BCD:    if (bcd_done) state_d = S_COMMIT;
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (datapath strobes)
  // ---------------------------------------------------------------------------
  always_comb begin
    cap_en    = 1'b0;
    min_en    = 1'b0;
    sec_en    = 1'b0;
    bcd_en    = 1'b0;
    commit_en = 1'b0;
    case (state_q)
      S_IDLE:   cap_en    = 1'b1;
      S_MIN:    min_en    = 1'b1;
      S_SEC:    sec_en    = 1'b1;
      S_BCD:    bcd_en    = 1'b1;
      S_COMMIT: commit_en = 1'b1;
      default:  ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Converter datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    r_d        = r_q;
    mcnt_d     = mcnt_q;
    scnt_d     = scnt_q;
    sat_d      = sat_q;
    min_t_d    = min_t_q;
    sec_t_d    = sec_t_q;
    ms_h_d     = ms_h_q;
    ms_t_d     = ms_t_q;
    ms_ph_d    = ms_ph_q;
    dig_d      = dig_q;
    ovf_d      = ovf_q;
    cvt_done_d = commit_en;

    if (cap_en) begin
      r_d     = RW'(t);
      mcnt_d  = '0;
      scnt_d  = '0;
      sat_d   = 1'b0;
      min_t_d = '0;
      sec_t_d = '0;
      ms_h_d  = '0;
      ms_t_d  = '0;
      ms_ph_d = 1'b0;
    end else if (min_en) begin
      if (min_step) begin
        r_d    = r_q - MS_PER_MIN;
        mcnt_d = mcnt_q + 7'd1;
      end else if (r_q >= MS_PER_MIN) begin
        // 99 minutes used up and time still remains: clamp to 99:59.999.
        sat_d  = 1'b1;
        mcnt_d = 7'd99;
        r_d    = MS_MAX_REM;
      end
    end else if (sec_en) begin
      if (r_q >= MS_PER_SEC) begin
        r_d    = r_q - MS_PER_SEC;
        scnt_d = scnt_q + 6'd1;
      end
    end else if (bcd_en) begin
      // All three fields reduce in parallel; the slowest one sets the exit.
      if (mcnt_q >= 7'd10) begin
        mcnt_d  = mcnt_q - 7'd10;
        min_t_d = min_t_q + 4'd1;
      end
      if (scnt_q >= 6'd10) begin
        scnt_d  = scnt_q - 6'd10;
        sec_t_d = sec_t_q + 4'd1;
      end
      if (!ms_ph_q) begin
        if (r_q >= MS_100) begin
          r_d    = r_q - MS_100;
          ms_h_d = ms_h_q + 4'd1;
        end else begin
          ms_ph_d = 1'b1;
        end
      end else if (r_q >= MS_10) begin
        r_d    = r_q - MS_10;
        ms_t_d = ms_t_q + 4'd1;
      end
    end else if (commit_en) begin
      // All digits and ovf load on the same edge, so no torn value is shown.
      dig_d = {min_t_q, mcnt_q[3:0], sec_t_q, scnt_q[3:0], ms_h_q, ms_t_q, r_q[3:0]};
      ovf_d = sat_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan, blink and registered display outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    scan_wrap   = (scan_cnt_q == SCAN_W'(REFRESH_DIV - 1));
    scan_cnt_d  = scan_wrap ? '0 : scan_cnt_q + SCAN_W'(1);
    slot_d      = scan_wrap ? slot_q - 3'd1 : slot_q;   // 7 -> 6 -> ... -> 0 -> 7

    blink_wrap  = (blink_cnt_q == BLINK_W'(BLINK_DIV - 1));
    blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + BLINK_W'(1);
    // Outside blinking the phase is held on, so it restarts "on" when zero falls.
    phase_on_d  = !zero ? 1'b1 : (blink_wrap ? !phase_on_q : phase_on_q);

    case (slot_q)
      3'd6:    cur_dig = dig_q[6];
      3'd5:    cur_dig = dig_q[5];
      3'd4:    cur_dig = dig_q[4];
      3'd3:    cur_dig = dig_q[3];
      3'd2:    cur_dig = dig_q[2];
      3'd1:    cur_dig = dig_q[1];
      3'd0:    cur_dig = dig_q[0];
      default: cur_dig = 4'hF;
    endcase

    blank = zero && !phase_on_q;
    an_d  = 8'hFF;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (!blank && (slot_q != 3'd7)) begin
      an_d  = ~(8'd1 << slot_q);
      seg_d = seg_enc(cur_dig);
      dp_d  = !((slot_q == 3'd5) || (slot_q == 3'd3));
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: every flop, including the digit store, has a reset value so the
    // display and the converter start from a defined state on any reset.
    if (rst) begin
      state_q     <= S_IDLE;
      r_q         <= '0;
      mcnt_q      <= '0;
      scnt_q      <= '0;
      sat_q       <= 1'b0;
      min_t_q     <= '0;
      sec_t_q     <= '0;
      ms_h_q      <= '0;
      ms_t_q      <= '0;
      ms_ph_q     <= 1'b0;
      dig_q       <= '0;
      ovf_q       <= 1'b0;
      cvt_done_q  <= 1'b0;
      scan_cnt_q  <= '0;
      slot_q      <= 3'd7;
      blink_cnt_q <= '0;
      phase_on_q  <= 1'b1;
      an_q        <= 8'hFF;
      seg_q       <= 7'h7F;
      dp_q        <= 1'b1;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values of the others.
      state_q     <= state_d;
      r_q         <= r_d;
      mcnt_q      <= mcnt_d;
      scnt_q      <= scnt_d;
      sat_q       <= sat_d;
      min_t_q     <= min_t_d;
      sec_t_q     <= sec_t_d;
      ms_h_q      <= ms_h_d;
      ms_t_q      <= ms_t_d;
      ms_ph_q     <= ms_ph_d;
      dig_q       <= dig_d;
      ovf_q       <= ovf_d;
      cvt_done_q  <= cvt_done_d;
      scan_cnt_q  <= scan_cnt_d;
      slot_q      <= slot_d;
      blink_cnt_q <= blink_cnt_d;
      phase_on_q  <= phase_on_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign an       = an_q;
  assign seg      = seg_q;
  assign dp       = dp_q;
  assign ovf      = ovf_q;
  assign cvt_done = cvt_done_q;

endmodule

// File: tb/tb_stopwatch_display.sv
// Testbench for stopwatch_display with short scan/blink periods.
// The driver changes t right after each cvt_done (before the next capture)
// and pushes the expected result of the conversion that will use it; the
// monitor pops on every cvt_done and checks the display output every cycle.
module tb_stopwatch_display;

  localparam int T_W         = 23;
  localparam int REFRESH_DIV = 4;
  localparam int BLINK_DIV   = 16;

  logic           clk;
  logic           rst;
  logic [T_W-1:0] t;
  logic           zero;
  logic [7:0]     an;
  logic [6:0]     seg;
  logic           dp;
  logic           ovf;
  logic           cvt_done;

  typedef struct packed {
    logic [6:0][3:0] dig;
    logic            ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  stopwatch_display #(
    .T_W        (T_W),
    .REFRESH_DIV(REFRESH_DIV),
    .BLINK_DIV  (BLINK_DIV)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .t       (t),
    .zero    (zero),
    .an      (an),
    .seg     (seg),
    .dp      (dp),
    .ovf     (ovf),
    .cvt_done(cvt_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (time %0t)", name, act, req, $time);
  endtask

  // Reference: plain arithmetic on the time value.
  function automatic exp_t model(input int unsigned tv);
    exp_t e;
    int unsigned m, s, ms;
    if (tv >= 6000000) begin
      m = 99; s = 59; ms = 999; e.ovf = 1'b1;
    end else begin
      m = tv / 60000; s = (tv % 60000) / 1000; ms = tv % 1000; e.ovf = 1'b0;
    end
    e.dig[6] = 4'(m / 10);
    e.dig[5] = 4'(m % 10);
    e.dig[4] = 4'(s / 10);
    e.dig[3] = 4'(s % 10);
    e.dig[2] = 4'(ms / 100);
    e.dig[1] = 4'((ms / 10) % 10);
    e.dig[0] = 4'(ms % 10);
    return e;
  endfunction

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
      4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
      4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic reset_checks(input string tag);
    check({tag, "_an"}, 32'(an), 32'h0FF);
    check({tag, "_seg"}, 32'(seg), 32'h07F);
    check({tag, "_dp"}, 32'(dp), 32'h1);
    check({tag, "_ovf"}, 32'(ovf), 32'h0);
    check({tag, "_cvt_done"}, 32'(cvt_done), 32'h0);
  endtask

  task automatic wait_done();
    int   cyc;
    logic seen;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 250) begin
      @(negedge clk);
      cyc++;
      seen = cvt_done;
    end
    check("cvt_done_in_time", 32'(seen), 32'h1);
  endtask

  // Wait for the current conversion to finish, then present the time for
  // the next one (captured on the following edge).
  task automatic next_conv(input int unsigned tv);
    wait_done();
    t = T_W'(tv);
    exp_q.push_back(model(tv));
  endtask

  // Monitor: cycle-level display model plus scoreboard pop on cvt_done.
  initial begin : monitor
    int              n;
    int              since;
    logic            ph;
    logic            z;
    logic            blank_m;
    logic [2:0]      sl;
    logic [6:0][3:0] disp;
    logic            ovf_m;
    logic [7:0]      an_e;
    logic [6:0]      seg_e;
    logic            dp_e;
    exp_t            e;
    n = 0; since = 0; ph = 1'b1; disp = '0; ovf_m = 1'b0;
    forever begin
      @(posedge clk);
      if (rst) begin
        n = 0; since = 0; ph = 1'b1; disp = '0; ovf_m = 1'b0;
      end else begin
        n++;
        z       = zero;
        blank_m = z && !ph;
        if (!z) ph = 1'b1;
        else if (n % BLINK_DIV == 0) ph = !ph;
        sl = 3'(7 - (((n - 1) / REFRESH_DIV) % 8));
        #1;
        an_e = 8'hFF; seg_e = 7'h7F; dp_e = 1'b1;
        if (!blank_m && sl != 3'd7) begin
          an_e  = ~(8'd1 << sl);
          seg_e = enc(disp[sl]);
          dp_e  = (sl == 3'd5 || sl == 3'd3) ? 1'b0 : 1'b1;
        end
        check("an", 32'(an), 32'(an_e));
        check("seg", 32'(seg), 32'(seg_e));
        check("dp", 32'(dp), 32'(dp_e));
        since++;
        if (cvt_done) begin
          check("cvt_latency_le_201", 32'(since <= 201), 32'h1);
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_cvt_done: got pulse, required none (time %0t)", $time);
          end else begin
            e     = exp_q.pop_front();
            disp  = e.dig;
            ovf_m = e.ovf;
          end
          since = 0;
        end
        check("ovf", 32'(ovf), 32'(ovf_m));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    rst = 1'b1; t = '0; zero = 1'b0;
    #1;
    reset_checks("por");
    repeat (3) @(negedge clk);
    reset_checks("rst_hold");
    exp_q.push_back(model(0));
    rst = 1'b0;

    // Directed values, including the saturation boundaries.
    next_conv(83456);
    next_conv(59999);
    next_conv(60000);
    next_conv(5999999);
    next_conv(6000000);
    next_conv(8388607);

    // Blink window during a long conversion.
    zero = 1'b1;
    repeat (100) @(negedge clk);
    zero = 1'b0;

    // t changes mid-conversion: first commit 1000, next 2000.
    next_conv(1000);
    repeat (3) @(negedge clk);
    t = T_W'(2000);
    next_conv(2000);

    // Reset in the middle of the minutes loop.
    next_conv(4000000);
    repeat (20) @(negedge clk);
    #2 rst = 1'b1;
    #1 reset_checks("async_rst");
    exp_q.delete();
    repeat (2) @(negedge clk);
    exp_q.push_back(model(4000000));
    rst = 1'b0;
    next_conv(4000000);

    // Randomised values with random blink enable.
    for (int i = 0; i < 20; i++) begin
      int unsigned tv;
      if ($urandom_range(0, 3) == 0) tv = $urandom_range(6000000, 8388607);
      else                           tv = $urandom_range(0, 5999999);
      next_conv(tv);
      zero = ($urandom_range(0, 2) == 0);
    end
    zero = 1'b0;

    wait_done();
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_display.md
Name: stopwatch_display

Overview:
- Downstream consumer of the stopwatch time output. Takes the running time in milliseconds and converts it to MM:SS.mmm BCD digits with a sequential converter.
- Drives the Nexys A7 8-digit multiplexed seven-segment display.
- Blinks the display while the stopwatch countdown-expired flag (zero) is high.

Parameters:
- T_W, 23, width of time input in ms.
- REFRESH_DIV, 100000, clk cycles per digit scan slot (1 kHz per digit at 100 MHz).
- BLINK_DIV, 25000000, clk cycles per blink half-period (2 Hz blink at 100 MHz).

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  asynchronous active-high reset.
- t  input  T_W  stopwatch time in milliseconds, unsigned.
- zero  input  1  countdown expired; enables blinking.
- an  output  8  digit anodes, active-low; an[7] is leftmost.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low.
- ovf  output  1  high while displayed value is saturated.
- cvt_done  output  1  one-cycle pulse when new digits are committed.

Behaviour:
- Reset (async, rst=1), all outputs forced immediately:
  - an=8'hFF, seg=7'h7F, dp=1, ovf=0, cvt_done=0.
  - Display digit registers=0; FSM in IDLE; scan and blink counters=0; blink phase=on.
- Converter FSM states: IDLE, MIN, SEC, BCD, COMMIT.
  - IDLE: capture t into work register r (zero-extended to max(T_W,23) bits); go to MIN. There is exactly one IDLE cycle, so conversions run back-to-back.
  - MIN: each cycle, if r>=60000 and mcnt<99, then r-=60000 and mcnt++. Else:
    - if r>=60000 (saturated), set sat=1, force mcnt=99 and r=59999;
    - go to SEC.
  - SEC: each cycle, if r>=1000, then r-=1000 and scnt++; else go to BCD. The remainder r is ms (0..999).
  - BCD: split mcnt, scnt and ms into 7 decimal digits by repeated subtraction, one subtraction per cycle per field, all fields in parallel:
    - hundreds, then tens; remainder is units;
    - exit when all fields are finished.
  - COMMIT: load all 7 display digit registers and ovf<=sat simultaneously (atomic, no torn values). Pulse cvt_done for 1 cycle; go to IDLE.
- Latency and sampling:
  - Worst-case latency from IDLE capture to cvt_done is ≤ 200 cycles.
  - t changes during a conversion are ignored until the next IDLE.
- Digit map:
  - an[7] blank (anode held off).
  - an[6:5] minutes tens/units; an[4:3] seconds tens/units; an[2:0] ms hundreds/tens/units.
  - dp low on an[5] and an[3] slots only.
- Scan:
  - Scan counter counts 0..REFRESH_DIV-1; at wrap, advance slot index 7→6→…→0→7.
  - Exactly one anode low at a time, except slot 7, where all anodes are high.
  - seg/dp are registered together with an, so they change on the same clk edge.
  - Digit encoding is standard 0-9; codes 10-15 display blank.
- Blink:
  - Blink counter free-runs 0..BLINK_DIV-1 and toggles the blink phase at wrap.
  - While zero=1 and phase=off: an=8'hFF, seg=7'h7F, dp=1.
  - When zero falls, the display is restored on the next clk edge, and phase resets to on.
- Saturation: t ≥ 6,000,000 displays 99:59.999 with ovf=1. t=5,999,999 displays 99:59.999 with ovf=0.
- Reset mid-conversion: work registers are cleared and the partial result is discarded; conversion restarts from IDLE after rst falls.

Test Plan (sim with REFRESH_DIV=4, BLINK_DIV=16):
- rst=1 then release, t=0 → during reset an=FF, seg=7F, dp=1. After first cvt_done, digits 00:00.000; slot an[6] low shows seg=7'h40 ("0").
- t=83456 → after cvt_done, digit registers 0,1,2,3,4,5,6. dp low exactly in slots an[5] and an[3]; an[7] never low; each slot lasts 4 clk.
- t=5999999 → 99:59.999, ovf=0. t=6000000 → 99:59.999, ovf=1. t=8388607 → 99:59.999, ovf=1. Each case: cvt_done within 200 cycles.
- t changes from 1000 to 2000 mid-conversion → the first cvt_done commits 00:01.000 and the next commits 00:02.000. No intermediate mixed digits are ever visible.
- zero=1 → outputs go blank for 16 clk, then normal for 16 clk, repeating. zero=0 → normal scanning resumes on the next edge.
- rst pulsed during MIN state with t=4,000,000 → outputs go to reset values asynchronously, before any clk edge. After release, the next cvt_done shows 66:40.000.
